// File: rtl/menu_pkg.sv
// Shared constants and state type for the start-screen menu controller.
package menu_pkg;

  localparam logic [7:0] KEY_UP    = 8'h77;
  localparam logic [7:0] KEY_DOWN  = 8'h73;
  localparam logic [7:0] KEY_ENTER = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_LOCKED = 2'd2
  } menu_state_t;

  // Auto-repeat spacing, counted in navigation ticks.
  localparam logic [3:0] REP_FIRST = 4'd8;
  localparam logic [3:0] REP_NEXT  = 4'd2;

endpackage

// File: rtl/menu_arrow_ctrl_tick_divider.sv
// Free-running clock divider: one-cycle tick every DIV enabled clocks; en=0 freezes the count.
module tick_divider #(
  parameter int DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/menu_arrow_ctrl.sv
// Menu arrow selector: keyboard navigation over N_ITEMS slots, glyph painting into scanlines.
// Optional build macro MENU_AUTO_REPEAT_EN adds hold-to-repeat for 'w'/'s'.
module menu_arrow_ctrl
  import menu_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int LINE_W     = 480,
  parameter int ITEM_X0    = 192,
  parameter int ITEM_PITCH = 32,
  parameter int GLYPH_W    = 16,
  parameter int GLYPH_H    = 9,
  parameter logic [GLYPH_W*GLYPH_H-1:0] GLYPH = 144'h0000010001000100054007C0038001000000,
  parameter int ARROW_ROW  = 270,
  parameter int TICK_DIV   = 2500000,
  parameter int WRAP       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 ascii,
  input  logic                       key_valid,
  input  logic                       key_held,
  input  logic [9:0]                 h_addr,
  input  logic [0:LINE_W-1]          dis_line,
  output logic [0:LINE_W-1]          fall_line,
  output logic                       line_valid,
  output logic [9:0]                 w_addr,
  output logic [$clog2(N_ITEMS)-1:0] level,
  output logic                       start,
  output logic                       start_pulse,
  output logic                       led0
);

  localparam int LVL_W = $clog2(N_ITEMS);
  localparam int ROW_W = $clog2(GLYPH_H + 1);
  localparam int GBITS = GLYPH_W * GLYPH_H;

  menu_state_t        state;
  logic [7:0]         pend_key;
  logic               pend_valid;
  logic [ROW_W-1:0]   row;
  logic               tick;
  logic               key_ok;
  logic               consume;
  logic               row_hit;
  logic               rep_fire;
  logic               rep_up;
  logic [LVL_W-1:0]   lvl_up;
  logic [LVL_W-1:0]   lvl_dn;
  logic [GLYPH_W-1:0] glyph_row;
  logic [0:LINE_W-1]  paint_line;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_LOCKED),
    .tick (tick)
  );

  // key_valid is a one-cycle strobe with no back-pressure: the pending slot always
  // accepts a recognised key and the newest one wins until an IDLE tick consumes it.
  assign key_ok  = key_valid && (state != ST_LOCKED) &&
                   (ascii == KEY_UP || ascii == KEY_DOWN || ascii == KEY_ENTER);
  assign consume = (state == ST_IDLE) && tick && pend_valid;
  assign row_hit = (state == ST_DRAW) && ({1'b0, h_addr} == (11'(ARROW_ROW) + 11'(row)));

  assign lvl_up = (level == '0) ? ((WRAP != 0) ? LVL_W'(N_ITEMS - 1) : '0) : level - LVL_W'(1);
  assign lvl_dn = (level == LVL_W'(N_ITEMS - 1)) ? ((WRAP != 0) ? '0 : level) : level + LVL_W'(1);

  always_comb begin
    glyph_row = '0;
    for (int i = 0; i < GLYPH_H; i++) begin
      if (row == ROW_W'(i)) glyph_row = GLYPH[GBITS-1-i*GLYPH_W -: GLYPH_W];
    end
  end

  // Every slot is blanked; only the selected one receives the glyph row (MSB = leftmost pixel).
  always_comb begin
    paint_line = dis_line;
    for (int k = 0; k < N_ITEMS; k++) begin
      for (int j = 0; j < GLYPH_W; j++) begin
        paint_line[ITEM_X0+k*ITEM_PITCH+j] = (level == LVL_W'(k)) ? glyph_row[GLYPH_W-1-j] : 1'b0;
      end
    end
  end

`ifdef MENU_AUTO_REPEAT_EN
  logic       rep_on;
  logic       rep_first;
  logic [3:0] rep_cnt;

  // A repeat that falls due outside IDLE is held until the first IDLE tick.
  assign rep_fire = rep_on && key_held && tick && (state == ST_IDLE) && !pend_valid &&
                    (rep_cnt >= (rep_first ? REP_FIRST - 4'd1 : REP_NEXT - 4'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_on    <= 1'b0;
      rep_up    <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (!key_held) begin
      rep_on <= 1'b0;
    end else if (consume && pend_key != KEY_ENTER) begin
      rep_on    <= 1'b1;
      rep_up    <= (pend_key == KEY_UP);
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_fire) begin
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_on && tick && rep_cnt != 4'hF) begin
      rep_cnt <= rep_cnt + 4'd1;
    end
  end
`else
  assign rep_fire = key_held & 1'b0;
  assign rep_up   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_DRAW;
      pend_key    <= '0;
      pend_valid  <= 1'b0;
      row         <= '0;
      level       <= '0;
      start       <= 1'b0;
      start_pulse <= 1'b0;
      led0        <= 1'b0;
      fall_line   <= '0;
      line_valid  <= 1'b0;
      w_addr      <= '0;
    end else begin
      start_pulse <= 1'b0;
      line_valid  <= 1'b0;
      if (key_ok) begin
        pend_key   <= ascii;
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (consume) begin
            led0 <= ~led0;
            if (pend_key == KEY_ENTER) begin
              start       <= 1'b1;
              start_pulse <= 1'b1;
              state       <= ST_LOCKED;
            end else begin
              level <= (pend_key == KEY_UP) ? lvl_up : lvl_dn;
              state <= ST_DRAW;
            end
          end else if (rep_fire) begin
            level <= rep_up ? lvl_up : lvl_dn;
            state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (row_hit) begin
            fall_line  <= paint_line;
            w_addr     <= h_addr;
            line_valid <= 1'b1;
            if (row == ROW_W'(GLYPH_H - 1)) begin
              row   <= '0;
              state <= ST_IDLE;
            end else begin
              row <= row + ROW_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_arrow_ctrl.sv
// Bench for menu_arrow_ctrl: a wrapping and a clamping instance driven with the same keys and scanlines.
module tb_menu_arrow_ctrl;

  localparam int DIV   = 4;
  localparam int N     = 4;
  localparam int LW    = 480;
  localparam int X0    = 192;
  localparam int PITCH = 32;
  localparam int GW    = 16;
  localparam int GH    = 9;
  localparam int AROW  = 270;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      ascii = 8'h00;
  logic            key_valid = 1'b0;
  logic            key_held = 1'b0;
  logic [9:0]      h_addr = 10'd0;
  logic [0:LW-1]   dis_line = '0;

  logic [0:LW-1]   fl   [2];
  logic            lv   [2];
  logic [9:0]      wa   [2];
  logic [1:0]      lvl  [2];
  logic            st   [2];
  logic            sp   [2];
  logic            led  [2];

  logic [GW*GH-1:0] glyph_v = 144'h0000010001000100054007C0038001000000;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  menu_arrow_ctrl #(.TICK_DIV(DIV), .WRAP(1)) dut (
    .clk(clk), .rst(rst), .ascii(ascii), .key_valid(key_valid), .key_held(key_held),
    .h_addr(h_addr), .dis_line(dis_line), .fall_line(fl[0]), .line_valid(lv[0]),
    .w_addr(wa[0]), .level(lvl[0]), .start(st[0]), .start_pulse(sp[0]), .led0(led[0])
  );

  menu_arrow_ctrl #(.TICK_DIV(DIV), .WRAP(0)) dut_c (
    .clk(clk), .rst(rst), .ascii(ascii), .key_valid(key_valid), .key_held(key_held),
    .h_addr(h_addr), .dis_line(dis_line), .fall_line(fl[1]), .line_valid(lv[1]),
    .w_addr(wa[1]), .level(lvl[1]), .start(st[1]), .start_pulse(sp[1]), .led0(led[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;  // 0 idle, 1 drawing, 2 locked
  int          m_row;
  int          m_cnt;
  logic [7:0]  m_pend;
  bit          m_pv;
  int          m_lvl [2];
  bit          m_led, m_start, m_sp, m_lv;
  logic [489:0] exp_q[$];
  logic [489:0] exp_c_q[$];

  function automatic logic [0:LW-1] model_line(input logic [0:LW-1] bg, input int sel, input int r);
    logic [0:LW-1] ln;
    int off, slot;
    ln = bg;
    for (int c = X0; c < X0 + N * PITCH; c++) begin
      slot = (c - X0) / PITCH;
      off  = (c - X0) % PITCH;
      if (off < GW) ln[c] = (slot == sel) ? glyph_v[GW*GH-1 - r*GW - off] : 1'b0;
    end
    return ln;
  endfunction

  function automatic int next_level(input int cur, input bit up, input bit wrap);
    if (wrap) return up ? (cur + N - 1) % N : (cur + 1) % N;
    if (up) return (cur > 0) ? cur - 1 : 0;
    return (cur < N - 1) ? cur + 1 : N - 1;
  endfunction

  always @(posedge clk) begin
    int ph0;
    bit tk, cons;
    if (rst) begin
      m_phase = 1; m_row = 0; m_cnt = 0; m_pend = 8'h00; m_pv = 0;
      m_lvl[0] = 0; m_lvl[1] = 0; m_led = 0; m_start = 0; m_sp = 0; m_lv = 0;
    end else begin
      ph0  = m_phase;
      tk   = (ph0 != 2) && (m_cnt == DIV - 1);
      cons = 0;
      m_lv = 0;
      m_sp = 0;
      if (ph0 == 0 && tk && m_pv) begin
        cons  = 1;
        m_led = !m_led;
        if (m_pend == 8'h0D) begin
          m_start = 1; m_sp = 1; m_phase = 2;
        end else begin
          for (int d = 0; d < 2; d++) m_lvl[d] = next_level(m_lvl[d], m_pend == 8'h77, d == 0);
          m_phase = 1;
        end
      end else if (ph0 == 1 && int'(h_addr) == AROW + m_row) begin
        exp_q.push_back({h_addr, model_line(dis_line, m_lvl[0], m_row)});
        exp_c_q.push_back({h_addr, model_line(dis_line, m_lvl[1], m_row)});
        m_lv = 1;
        m_row++;
        if (m_row == GH) begin m_row = 0; m_phase = 0; end
      end
      if (ph0 != 2 && key_valid && (ascii == 8'h77 || ascii == 8'h73 || ascii == 8'h0D)) begin
        m_pend = ascii; m_pv = 1;
      end else if (cons) begin
        m_pv = 0;
      end
      if (ph0 != 2) m_cnt = (m_cnt + 1) % DIV;
    end
  end

  // ---------------- scoreboard / compare ----------------
  int           lv_cnt [2];
  int           sp_cnt;
  logic [0:LW-1] cap [2];
  logic [1:0]   lvl_at_278;

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [489:0] e;
      bit have;
      chk($sformatf("line_valid%0d", d), 32'(lv[d]), 32'(m_lv));
      chk($sformatf("level%0d", d), 32'(lvl[d]), 32'(m_lvl[d]));
      chk($sformatf("start%0d", d), 32'(st[d]), 32'(m_start));
      chk($sformatf("start_pulse%0d", d), 32'(sp[d]), 32'(m_sp));
      chk($sformatf("led0_%0d", d), 32'(led[d]), 32'(m_led));
      if (lv[d]) begin
        have = 0;
        e = '0;
        if (d == 0 && exp_q.size() > 0) begin e = exp_q.pop_front(); have = 1; end
        if (d == 1 && exp_c_q.size() > 0) begin e = exp_c_q.pop_front(); have = 1; end
        total++;
        if (!have || {wa[d], fl[d]} !== e) begin
          bad++;
          $display("FAIL line%0d: got %h expected %h", d, {wa[d], fl[d]}, e);
        end
        lv_cnt[d]++;
        if (wa[d] == 10'd275) cap[d] = fl[d];
        if (d == 0 && wa[d] == 10'd278) lvl_at_278 = lvl[d];
      end
    end
    if (sp[0]) sp_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    ascii = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    ascii = 8'h00;
  endtask

  task automatic sweep(input logic [0:LW-1] bg);
    dis_line = bg;
    for (int h = 0; h < LW; h++) begin
      h_addr = 10'(h);
      @(negedge clk);
    end
    h_addr = 10'd0;
  endtask

  function automatic logic [15:0] slot_bits(input logic [0:LW-1] ln, input int x);
    return ln[x +: 16];
  endfunction

  logic [0:LW-1] ones = '1;
  logic [0:LW-1] zeros = '0;
  logic [0:LW-1] pat_a;
  logic [0:LW-1] pat_b;

  initial begin
    for (int i = 0; i < LW; i++) begin
      pat_a[i] = (i % 2 == 0);
      pat_b[i] = (i % 3 != 0);
    end
    lv_cnt[0] = 0; lv_cnt[1] = 0; sp_cnt = 0; lvl_at_278 = '0;
    cap[0] = '0; cap[1] = '0;
    @(negedge clk);

    // reset state and the power-up repaint at slot 0
    do_reset();
    chk("rst_level", 32'(lvl[0]), 32'd0);
    chk("rst_line_valid", 32'(lv[0]), 32'd0);
    chk("rst_start", 32'(st[0]), 32'd0);
    chk("rst_led0", 32'(led[0]), 32'd0);
    lv_cnt[0] = 0;
    sweep(ones);
    chk("rows_drawn", 32'(lv_cnt[0]), 32'd9);
    chk("row5_slot0", 32'(slot_bits(cap[0], 192)), 32'h07C0);
    chk("row5_slot1_cleared", 32'(slot_bits(cap[0], 224)), 32'h0000);
    chk("row5_background", 32'(slot_bits(cap[0], 0)), 32'hFFFF);

    // 's' latched in the same cycle as a tick waits for the following tick
    for (int i = 0; i < 2 * DIV && m_cnt != DIV - 1; i++) @(negedge clk);
    press(8'h73);
    chk("same_cycle_key_waits", 32'(lvl[0]), 32'd0);
    cycles(6);
    chk("first_s_level", 32'(lvl[0]), 32'd1);
    sweep(pat_a);
    press(8'h73);
    cycles(6);
    sweep(pat_b);
    chk("two_s_level", 32'(lvl[0]), 32'd2);
    chk("two_s_led0", 32'(led[0]), 32'd0);
    chk("row5_slot2", 32'(slot_bits(cap[0], 256)), 32'h07C0);
    chk("row5_slot0_cleared", 32'(slot_bits(cap[0], 192)), 32'h0000);

    // 'w' at level 0: wrap vs clamp
    do_reset();
    sweep(ones);
    press(8'h77);
    cycles(6);
    chk("wrap_level", 32'(lvl[0]), 32'd3);
    chk("clamp_level", 32'(lvl[1]), 32'd0);
    chk("clamp_led0", 32'(led[1]), 32'd1);
    lv_cnt[0] = 0; lv_cnt[1] = 0;
    sweep(ones);
    chk("clamp_repaint_rows", 32'(lv_cnt[1]), 32'd9);
    chk("clamp_row5_slot0", 32'(slot_bits(cap[1], 192)), 32'h07C0);
    chk("wrap_row5_slot3", 32'(slot_bits(cap[0], 288)), 32'h07C0);

    // 'w' during DRAW stays pending until after row 278 and a tick
    do_reset();
    press(8'h77);
    cycles(10);
    chk("pending_in_draw", 32'(lvl[0]), 32'd0);
    sweep(pat_a);
    chk("level_at_row278", 32'(lvl_at_278), 32'd0);
    cycles(6);
    chk("pending_applied", 32'(lvl[0]), 32'd3);
    sweep(pat_b);

    // Enter at level 2 locks the menu
    do_reset();
    sweep(zeros);
    press(8'h73);
    cycles(6);
    sweep(zeros);
    press(8'h73);
    cycles(6);
    sweep(zeros);
    sp_cnt = 0;
    press(8'h0D);
    cycles(6);
    chk("start_pulse_width", 32'(sp_cnt), 32'd1);
    chk("start_held", 32'(st[0]), 32'd1);
    chk("locked_level", 32'(lvl[0]), 32'd2);
    press(8'h73);
    press(8'h73);
    cycles(10);
    lv_cnt[0] = 0;
    sweep(ones);
    chk("locked_no_draw", 32'(lv_cnt[0]), 32'd0);
    chk("locked_level_kept", 32'(lvl[0]), 32'd2);

    // asynchronous reset out of LOCKED
    rst = 1'b1;
    #1;
    chk("async_rst_start", 32'(st[0]), 32'd0);
    chk("async_rst_level", 32'(lvl[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lv_cnt[0] = 0;
    sweep(pat_a);
    chk("post_lock_rows", 32'(lv_cnt[0]), 32'd9);
    chk("post_lock_slot0", 32'(slot_bits(cap[0], 192)), 32'h07C0);

    cycles(4);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("exp_c_q_drained", 32'(exp_c_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/menu_arrow_ctrl.md
# menu_arrow_ctrl

Parametrised start-screen menu controller for the typing game. It takes keyboard ASCII codes, moves a selection arrow over `N_ITEMS` menu rows and paints the arrow glyph into the VGA scanline stream. On Enter it locks the chosen level and raises `start` for the game core. It sits between the keyboard decoder and the scanline merger, and generalises the fixed 4-level selector to any item count, pitch and glyph, with wrap-or-clamp navigation.

## Interface
Parameters:
- `N_ITEMS`, 4: number of menu items (2..16).
- `LINE_W`, 480: scanline width in pixels.
- `ITEM_X0`, 192: pixel column of item 0's arrow slot.
- `ITEM_PITCH`, 32: column distance between slots; must be ≥ `GLYPH_W`, and `ITEM_X0+N_ITEMS*ITEM_PITCH` ≤ `LINE_W`.
- `GLYPH_W`, 16: glyph width.
- `GLYPH_H`, 9: glyph height.
- `GLYPH`, 144'h0000010001000100054007C0038001000000: glyph bitmap, row 0 in the MSBs.
- `ARROW_ROW`, 270: first scanline of the glyph.
- `TICK_DIV`, 2500000: clocks per navigation tick.
- `WRAP`, 1: 1 = wrap at the ends; 0 = clamp at the ends.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `ascii` in 8: key code.
- `key_valid` in 1: one-cycle strobe; `ascii` is valid in that cycle.
- `key_held` in 1: key still pressed. Used only with `AUTO_REPEAT_EN`.
- `h_addr` in 10: current scanline index.
- `dis_line` in [0:LINE_W-1]: background scanline.
- `fall_line` out [0:LINE_W-1]: scanline with the arrow merged in.
- `line_valid` out 1: `fall_line` and `w_addr` are valid this cycle.
- `w_addr` out 10: scanline index that `fall_line` belongs to.
- `level` out clog2(N_ITEMS): current selection.
- `start` out 1: level-held; set after Enter.
- `start_pulse` out 1: one-cycle pulse on Enter.
- `led0` out 1: toggles on every accepted key.

## Operation
- Key capture: a `key_valid` strobe carrying 'w' (8'h77), 's' (8'h73) or Enter (8'h0D) is stored in a 1-entry pending register. A newer strobe overwrites the pending key. All other codes are ignored.
- Tick: a free-running divider asserts `tick` for one cycle every `TICK_DIV` clocks.
- FSM states: IDLE, DRAW, LOCKED.
- IDLE, `tick` with a key pending. The pending register is consumed and `led0` toggles.
  - 'w': `level` − 1. From 0 it goes to `N_ITEMS`−1 if `WRAP`, otherwise stays at 0. Next state DRAW.
  - 's': `level` + 1. From `N_ITEMS`−1 it goes to 0 if `WRAP`, otherwise stays at `N_ITEMS`−1. Next state DRAW.
  - Enter: `start`=1, `start_pulse`=1 for one cycle. Next state LOCKED.
- A clamped move still toggles `led0` and still enters DRAW.
- DRAW: a row counter `r` runs 0..`GLYPH_H`−1. When `h_addr == ARROW_ROW + r`:
  - `fall_line` = `dis_line` with every slot [ITEM_X0+k*ITEM_PITCH, +GLYPH_W) cleared.
  - Glyph row `r` is then written into slot `level`.
  - `w_addr` = `h_addr`, `line_valid`=1, `r` increments.
  - After row `GLYPH_H`−1 the FSM returns to IDLE.
  - `h_addr` values that do not match leave `line_valid`=0.
- LOCKED: the FSM is terminal. Keys are ignored, the divider halts, and only `rst` leaves this state.
- Keys that arrive during DRAW remain pending and are processed at the first tick after returning to IDLE.

## Timing
- Reset values: `fall_line`=0, `line_valid`=0, `w_addr`=0, `level`=0, `start`=0, `start_pulse`=0, `led0`=0, pending empty, divider=0, `r`=0.
- After reset the FSM is in DRAW, so the arrow is painted once at level 0.
- Key to state update: at most `TICK_DIV` clocks, taken at the first tick after the strobe.
- `h_addr` match to `fall_line`/`line_valid`: 1 clock (registered). `line_valid` is a single-cycle pulse per row.
- A `key_valid` strobe and a `tick` in the same cycle: the new key is latched and is processed at the next tick, not this one.
- Reset asserted mid-DRAW or in LOCKED: all registers return to their reset values immediately (asynchronous).
- All pixel arithmetic uses 11 bits so `ARROW_ROW + r` cannot overflow.

## Configuration
- `MENU_AUTO_REPEAT_EN` defined:
  - While a 'w' or 's' key has been accepted and `key_held` stays 1, the move repeats automatically.
  - The first repeat comes 8 ticks after acceptance, then one repeat every 2 ticks.
  - Repeats are issued only in IDLE.
  - Deasserting `key_held` stops repeats immediately.
- Not defined: `key_held` is ignored and every move requires a new `key_valid` strobe.

## Structure
- Shared package `menu_pkg` holds:
  - The ASCII constants `KEY_UP`, `KEY_DOWN`, `KEY_ENTER`.
  - The FSM state typedef `menu_state_t`.
  - The repeat constants `REP_FIRST`=8 and `REP_NEXT`=2.
- One sub-module, `tick_divider`: parameter `DIV`, with `clk`, `rst`, `en` inputs and a one-cycle `tick` output.

## Test plan
- Reset, then sweep `h_addr` 0..479: rows 270..278 each produce `line_valid`, and the glyph appears at columns 192..207. For row 5 the slot contains 16'h07C0.
- 's' twice, with `TICK_DIV`=4 in simulation: `level`=2, the next DRAW places the glyph at columns 256..271, `led0` ends at 0.
- `WRAP`=1 at level 0, press 'w': `level`=3. With `WRAP`=0 the same press leaves `level`=0, `led0` toggles, and DRAW still repaints.
- 'w' pressed during DRAW is held pending: `level` changes only after row 278 has been emitted and the next tick arrives.
- Enter at level 2: `start_pulse` high for exactly 1 clock, `start`=1, `level`=2; later 's' strobes change nothing.
- `rst` pulsed in LOCKED: `start`=0, `level`=0, arrow repainted at slot 0. With `MENU_AUTO_REPEAT_EN`, holding 's' for 20 ticks gives `level` sequence 1, 2, 3, 0, 1, 2, … on ticks 0, 8, 10, 12, …
